// File: rtl/alu_arbiter.sv
// Round-robin sharing of one registered EX-stage ALU between two requesters.
// Results return in acceptance order through a per-port response FIFO.
module alu_arbiter #(
    parameter int WIDTH     = 32,
    parameter int RSP_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_control,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_control,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_overflow,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_out,
    output logic             rsp0_overflow,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_out,
    output logic             rsp1_overflow
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RSP_DEPTH);

    typedef struct packed {
        logic             ovf;
        logic [WIDTH-1:0] data;
    } rsp_t;

    logic [1:0]       req_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] req_a    [2];
    logic [WIDTH-1:0] req_b    [2];
    logic [3:0]       req_ctrl [2];

    logic [1:0] elig;
    logic [1:0] grant;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] rsp_valid;
    logic       accept;
    logic       acc_port;

    logic             last_grant_q, last_grant_d;
    logic             i_valid_q, i_valid_d;
    logic             i_port_q, i_port_d;
    logic [WIDTH-1:0] i_a_q, i_a_d;
    logic [WIDTH-1:0] i_b_q, i_b_d;
    logic [3:0]       i_ctrl_q, i_ctrl_d;
    logic             f_valid_q;
    logic             f_port_q;
    logic             f_ovf_q;

    logic [CNT_W-1:0] out_q [2];
    logic [CNT_W-1:0] out_d [2];
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [PTR_W-1:0] wr_q  [2];
    logic [PTR_W-1:0] wr_d  [2];
    logic [PTR_W-1:0] rd_q  [2];
    logic [PTR_W-1:0] rd_d  [2];
    rsp_t             mem_q [2][RSP_DEPTH];
    rsp_t             head  [2];

    assign req_valid   = {req1_valid, req0_valid};
    assign rsp_ready   = {rsp1_ready, rsp0_ready};
    assign req_a[0]    = req0_a;
    assign req_a[1]    = req1_a;
    assign req_b[0]    = req0_b;
    assign req_b[1]    = req1_b;
    assign req_ctrl[0] = req0_control;
    assign req_ctrl[1] = req1_control;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // A port at its outstanding limit is not eligible, even if it pops this cycle.
    // Grants are held low during reset so ready never shows while rst_n is low.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            elig[p] = req_valid[p] && (out_q[p] < CNT_FULL);
        end
        grant[0] = rst_n && elig[0] && (!elig[1] || last_grant_q);
        grant[1] = rst_n && elig[1] && (!elig[0] || !last_grant_q);
    end

    assign accept   = |grant;
    assign acc_port = grant[1];

    // NOTE: combinational blocks assign a value on every path, so no latches are inferred.
    always_comb begin
        i_valid_d    = accept;
        i_port_d     = i_port_q;
        i_a_d        = i_a_q;
        i_b_d        = i_b_q;
        i_ctrl_d     = i_ctrl_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            i_port_d     = acc_port;
            i_a_d        = req_a[acc_port];
            i_b_d        = req_b[acc_port];
            i_ctrl_d     = req_ctrl[acc_port];
            last_grant_d = acc_port;
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rsp_valid[p] = (cnt_q[p] != '0);
            push[p]      = f_valid_q && (f_port_q == 1'(p));
            pop[p]       = rsp_valid[p] && rsp_ready[p];
            head[p]      = rsp_valid[p] ? mem_q[p][rd_q[p]] : '0;

            out_d[p] = out_q[p];
            if (grant[p] && !pop[p]) begin
                out_d[p] = out_q[p] + CNT_W'(1);
            end else if (!grant[p] && pop[p]) begin
                out_d[p] = out_q[p] - CNT_W'(1);
            end

            cnt_d[p] = cnt_q[p];
            if (push[p] && !pop[p]) begin
                cnt_d[p] = cnt_q[p] + CNT_W'(1);
            end else if (!push[p] && pop[p]) begin
                cnt_d[p] = cnt_q[p] - CNT_W'(1);
            end

            wr_d[p] = push[p] ? ptr_inc(wr_q[p]) : wr_q[p];
            rd_d[p] = pop[p]  ? ptr_inc(rd_q[p]) : rd_q[p];
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            i_valid_q    <= 1'b0;
            i_port_q     <= 1'b0;
            i_a_q        <= '0;
            i_b_q        <= '0;
            i_ctrl_q     <= '0;
            f_valid_q    <= 1'b0;
            f_port_q     <= 1'b0;
            f_ovf_q      <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                out_q[p] <= '0;
                cnt_q[p] <= '0;
                wr_q[p]  <= '0;
                rd_q[p]  <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            i_valid_q    <= i_valid_d;
            i_port_q     <= i_port_d;
            i_a_q        <= i_a_d;
            i_b_q        <= i_b_d;
            i_ctrl_q     <= i_ctrl_d;
            // The ALU registers its result on this same edge; only the flag is ours to keep.
            f_valid_q    <= i_valid_q;
            f_port_q     <= i_port_q;
            f_ovf_q      <= alu_overflow;
            for (int p = 0; p < 2; p++) begin
                out_q[p] <= out_d[p];
                cnt_q[p] <= cnt_d[p];
                wr_q[p]  <= wr_d[p];
                rd_q[p]  <= rd_d[p];
            end
        end
    end

    // NOTE: the response storage has no reset; the counts define what is valid and the head reads zero while empty.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push[p]) begin
                mem_q[p][wr_q[p]] <= rsp_t'{ovf: f_ovf_q, data: alu_out};
            end
        end
    end

    assign req0_ready    = grant[0];
    assign req1_ready    = grant[1];
    assign alu_a         = i_a_q;
    assign alu_b         = i_b_q;
    assign alu_control   = i_ctrl_q;
    assign rsp0_valid    = rsp_valid[0];
    assign rsp0_out      = head[0].data;
    assign rsp0_overflow = head[0].ovf;
    assign rsp1_valid    = rsp_valid[1];
    assign rsp1_out      = head[1].data;
    assign rsp1_overflow = head[1].ovf;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU plus a per-port expected-response
// model (queues of accepted ops with their acceptance cycle) checked every cycle.
module tb_alu_arbiter;

    localparam int W = 32;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]   req0_control, req1_control;
    logic [W-1:0] alu_a, alu_b;
    logic [3:0]   alu_control;
    logic [W-1:0] alu_out = '0;
    logic         alu_overflow;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready, rsp1_ready;
    logic [W-1:0] rsp0_out, rsp1_out;
    logic         rsp0_overflow, rsp1_overflow;
    logic [W:0]   alu_comb;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .RSP_DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_control (req0_control),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_control (req1_control),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_control  (alu_control),
        .alu_out      (alu_out),
        .alu_overflow (alu_overflow),
        .rsp0_valid   (rsp0_valid),
        .rsp0_ready   (rsp0_ready),
        .rsp0_out     (rsp0_out),
        .rsp0_overflow(rsp0_overflow),
        .rsp1_valid   (rsp1_valid),
        .rsp1_ready   (rsp1_ready),
        .rsp1_out     (rsp1_out),
        .rsp1_overflow(rsp1_overflow)
    );

    // Behavioural ALU: returns {flag, result}; flag is the carry out of add/sub.
    function automatic logic [W:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] c);
        logic [W:0] r;
        case (c[2:0])
            3'd0:    r = c[3] ? ({1'b0, a} + {1'b0, ~b} + (W+1)'(1)) : ({1'b0, a} + {1'b0, b});
            3'd1:    r = {1'b0, a << b[4:0]};
            3'd4:    r = {1'b0, a ^ b};
            3'd5:    r = {1'b0, a >> b[4:0]};
            3'd6:    r = {1'b0, a | b};
            3'd7:    r = {1'b0, a & b};
            default: r = {1'b0, a - b};
        endcase
        return r;
    endfunction

    assign alu_comb     = alu_ref(alu_a, alu_b, alu_control);
    assign alu_overflow = alu_comb[W];
    always @(posedge clk) alu_out <= alu_comb[W-1:0];

    typedef struct {
        int           cyc;
        logic [W-1:0] val;
        logic         ovf;
    } exp_t;

    exp_t         rq   [2][$];
    logic [W:0]   plog [2][$];
    int           obs_acc [2];
    int           obs_pop [2];
    int           first_v [2];
    int           cyc;
    logic         m_last;
    logic [W-1:0] m_a, m_b;
    logic [3:0]   m_c;
    int           n_vec = 0;
    int           n_miss = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int p = 0; p < 2; p++) begin
            rq[p].delete();
            plog[p].delete();
            obs_acc[p] = 0;
            obs_pop[p] = 0;
            first_v[p] = -1;
        end
        m_last = 1'b1;
        m_a    = '0;
        m_b    = '0;
        m_c    = '0;
        cyc    = 0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req0_ready"}, req0_ready, 0);
        check({pfx, "_req1_ready"}, req1_ready, 0);
        check({pfx, "_rsp0_valid"}, rsp0_valid, 0);
        check({pfx, "_rsp1_valid"}, rsp1_valid, 0);
        check({pfx, "_rsp0_out"}, rsp0_out, 0);
        check({pfx, "_rsp1_out"}, rsp1_out, 0);
        check({pfx, "_rsp0_ovf"}, rsp0_overflow, 0);
        check({pfx, "_rsp1_ovf"}, rsp1_overflow, 0);
        check({pfx, "_alu_a"}, alu_a, 0);
        check({pfx, "_alu_b"}, alu_b, 0);
        check({pfx, "_alu_control"}, alu_control, 0);
    endtask

    // One clock cycle: compare at the falling edge, advance the model, step past the rising edge.
    task automatic tick();
        logic [1:0]   v, e, g, rdy, rv, rr, of;
        logic [W-1:0] a [2];
        logic [W-1:0] b [2];
        logic [3:0]   c [2];
        logic [W-1:0] ro [2];
        logic [W:0]   r;
        logic         exp_v;
        exp_t         h;
        @(negedge clk);
        v   = {req1_valid, req0_valid};
        rdy = {rsp1_ready, rsp0_ready};
        rv  = {rsp1_valid, rsp0_valid};
        rr  = {req1_ready, req0_ready};
        of  = {rsp1_overflow, rsp0_overflow};
        a[0] = req0_a;   a[1] = req1_a;
        b[0] = req0_b;   b[1] = req1_b;
        c[0] = req0_control; c[1] = req1_control;
        ro[0] = rsp0_out; ro[1] = rsp1_out;

        for (int p = 0; p < 2; p++) e[p] = v[p] && (rq[p].size() < D);
        g[0] = e[0] && (!e[1] || m_last);
        g[1] = e[1] && (!e[0] || !m_last);

        check("req0_ready", rr[0], g[0]);
        check("req1_ready", rr[1], g[1]);
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("alu_control", alu_control, m_c);

        for (int p = 0; p < 2; p++) begin
            exp_v = (rq[p].size() > 0) && (rq[p][0].cyc + 3 <= cyc);
            check($sformatf("rsp%0d_valid", p), rv[p], exp_v);
            if (rv[p] && first_v[p] < 0) first_v[p] = cyc;
            if (rr[p] && v[p]) obs_acc[p]++;
            if (rv[p] && rdy[p]) begin
                obs_pop[p]++;
                plog[p].push_back({of[p], ro[p]});
            end
            if (exp_v) begin
                h = rq[p][0];
                check($sformatf("rsp%0d_out", p), ro[p], h.val);
                check($sformatf("rsp%0d_overflow", p), of[p], h.ovf);
                if (rdy[p]) void'(rq[p].pop_front());
            end
        end

        for (int p = 0; p < 2; p++) begin
            if (g[p]) begin
                r     = alu_ref(a[p], b[p], c[p]);
                h.cyc = cyc;
                h.val = r[W-1:0];
                h.ovf = r[W];
                rq[p].push_back(h);
                m_a    = a[p];
                m_b    = b[p];
                m_c    = c[p];
                m_last = 1'(p);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_control = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_control = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start;
        int pa0, pa1;
        rst_n      = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        idle_inputs();
        m_reset();

        // Reset state
        #1;
        check_reset_outputs("reset");
        do_reset();

        // Single op: 5 + 7 on port 0
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_control = 4'b0000;
        start = cyc;
        tick();
        req0_valid = 1'b0;
        repeat (5) tick();
        check("single_acc0", obs_acc[0], 1);
        check("single_acc1", obs_acc[1], 0);
        check("single_latency", first_v[0] - start, 3);
        check("single_count", plog[0].size(), 1);
        check("single_rsp", plog[0][0], {1'b0, 32'd12});
        check("single_p1_quiet", obs_pop[1], 0);

        // Contention from reset: alternating grants, port 0 first
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            req0_a = W'(obs_acc[0]);
            req1_a = W'(100 + obs_acc[1]);
            tick();
        end
        idle_inputs();
        repeat (5) tick();
        check("cont_acc0", obs_acc[0], 10);
        check("cont_acc1", obs_acc[1], 10);
        check("cont_cnt0", plog[0].size(), 10);
        check("cont_last0", plog[0][9], {1'b0, 32'd9});
        check("cont_last1", plog[1][9], {1'b0, 32'd109});

        // Backpressure: port 1 streams with its consumer stalled
        do_reset();
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_b = 32'd1;
        for (int i = 0; i < 10; i++) begin
            req1_a = W'(200 + obs_acc[1]);
            tick();
        end
        check("bp_accepted", obs_acc[1], 4);
        check("bp_no_pop", plog[1].size(), 0);
        rsp1_ready = 1'b1;
        for (int i = 0; i < 30 && obs_acc[1] < 6; i++) begin
            req1_a = W'(200 + obs_acc[1]);
            tick();
        end
        req1_valid = 1'b0;
        repeat (6) tick();
        check("bp_resume", obs_acc[1], 6);
        check("bp_count", plog[1].size(), 6);
        check("bp_first", plog[1][0], {1'b0, 32'd201});
        check("bp_fourth", plog[1][3], {1'b0, 32'd204});

        // Port isolation: port 1 full and stalled while port 0 streams
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd50; req1_b = 32'd3; req1_control = 4'b0100;
        for (int i = 0; i < 10 && obs_acc[1] < 4; i++) tick();
        check("iso_p1_full", obs_acc[1], 4);
        req0_valid = 1'b1; req0_b = 32'd7; req0_control = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            req0_a = W'(obs_acc[0] * 3);
            tick();
        end
        check("iso_acc0", obs_acc[0], 10);
        idle_inputs();
        rsp1_ready = 1'b1;
        repeat (8) tick();
        check("iso_cnt0", plog[0].size(), 10);
        check("iso_cnt1", plog[1].size(), 4);

        // Overflow alignment on back-to-back ops
        do_reset();
        rsp0_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_control = 4'b0000;
        tick();
        req0_a = 32'd1; req0_b = 32'd1;
        tick();
        req0_valid = 1'b0;
        repeat (5) tick();
        check("ovf_count", plog[0].size(), 2);
        check("ovf_first", plog[0][0], {1'b1, 32'd0});
        check("ovf_second", plog[0][1], {1'b0, 32'd2});

        // Asynchronous reset with three ops in flight
        do_reset();
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_b = 32'd1;
        for (int i = 0; i < 3; i++) begin
            req0_a = W'(10 + obs_acc[0]);
            tick();
        end
        check("midrst_accepted", obs_acc[0], 3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
        rsp0_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3; req0_control = 4'b0000;
        tick();
        req0_valid = 1'b0;
        repeat (6) tick();
        check("midrst_count", plog[0].size(), 1);
        check("midrst_rsp", plog[0][0], {1'b0, 32'd5});

        // Randomized traffic against the model
        do_reset();
        pa0 = 0;
        pa1 = 0;
        for (int t = 0; t < 400; t++) begin
            if (!req0_valid || obs_acc[0] != pa0) begin
                req0_valid   = ($urandom_range(0, 99) < 70);
                req0_a       = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                req0_b       = $urandom;
                req0_control = 4'($urandom_range(0, 15));
            end
            if (!req1_valid || obs_acc[1] != pa1) begin
                req1_valid   = ($urandom_range(0, 99) < 60);
                req1_a       = $urandom;
                req1_b       = ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom;
                req1_control = 4'($urandom_range(0, 15));
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 2) != 0);
            pa0 = obs_acc[0];
            pa1 = obs_acc[1];
            tick();
        end
        idle_inputs();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (10) tick();
        check("rand_drained0", obs_pop[0], obs_acc[0]);
        check("rand_drained1", obs_pop[1], obs_acc[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
